// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - matrix FIFO sizing constants, shared types and reader state encoding
package fifo_pkg;
  localparam int MAX_N  = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(MAX_N);
  localparam int CNT_W  = $clog2(MAX_N * MAX_N) + 1;

  typedef logic [3:0]       nibble_t;
  typedef logic [CNT_W-1:0] elem_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } reader_state_t;

  function automatic logic dim_ok(input nibble_t n, input int max_n);
    return (n != 4'd0) && (int'(n) <= max_n);
  endfunction
endpackage

// File: rtl/global_pkg.sv
// rtl/global_pkg.sv - project-wide boolean flag constants
package global_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/rc_counter.sv
// rtl/rc_counter.sv - row-major row/column index counter for an N x N matrix
module rc_counter
  import fifo_pkg::*;
#(
  parameter int IDX_W = fifo_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  nibble_t          N,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] row,
  output logic             last_col,
  output logic             last
);

  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_q, row_d;

  always_comb begin
    last_col = (nibble_t'(col_q) == N - 4'd1);
    last     = last_col && (nibble_t'(row_q) == N - 4'd1);
    col_d    = col_q;
    row_d    = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (inc) begin
      // Both indices wrap after the final element so a fresh matrix starts at (0,0).
      if (last) begin
        col_d = '0;
        row_d = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/matrix_fifo_reader.sv
// rtl/matrix_fifo_reader.sv - drains N*N elements from a FWFT FIFO into a registered valid/ready stage
module matrix_fifo_reader
  import fifo_pkg::*;
  import global_pkg::*;
#(
  parameter int MAX_N  = fifo_pkg::MAX_N,
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int IDX_W  = $clog2(MAX_N),
  parameter int CNT_W  = $clog2(MAX_N * MAX_N) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  nibble_t           N,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  reader_state_t     state_q;
  nibble_t           n_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  nn;
  logic [DATA_W-1:0] out_data_q;
  logic [IDX_W-1:0]  out_row_q, out_col_q;
  logic              out_valid_q, out_last_col_q, out_last_q, busy_q, done_q;
  logic [IDX_W-1:0]  rc_row, rc_col;
  logic              rc_last_col, rc_last;
  logic              start_ok, load;

  assign nn       = CNT_W'(n_q) * CNT_W'(n_q);
  assign start_ok = (state_q == ST_IDLE) && start && dim_ok(N, MAX_N);
  // The output slot is free when empty or being drained this cycle, giving one element per cycle.
  assign load     = (state_q == ST_STREAM) && (issued_q < nn) && !fifo_empty
                    && (!out_valid_q || out_ready);
  assign fifo_pop = load;

  rc_counter #(
    .IDX_W(IDX_W)
  ) u_rc (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .inc      (load),
    .N        (n_q),
    .col      (rc_col),
    .row      (rc_row),
    .last_col (rc_last_col),
    .last     (rc_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      issued_q       <= '0;
      out_data_q     <= '0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      out_valid_q    <= FALSE;
      out_last_col_q <= FALSE;
      out_last_q     <= FALSE;
      busy_q         <= FALSE;
      done_q         <= FALSE;
    end else begin
      done_q <= FALSE;
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            n_q      <= N;
            issued_q <= '0;
            busy_q   <= TRUE;
            state_q  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (load) begin
            out_data_q     <= fifo_data;
            out_row_q      <= rc_row;
            out_col_q      <= rc_col;
            out_last_col_q <= rc_last_col;
            out_last_q     <= (issued_q == nn - 1'b1);
            out_valid_q    <= TRUE;
            issued_q       <= issued_q + 1'b1;
            if (rc_last) begin
              state_q <= ST_FLUSH;
            end
          end else if (out_ready) begin
            out_valid_q <= FALSE;
          end
        end
        ST_FLUSH: begin
          if (out_valid_q && out_ready && out_last_q) begin
            out_valid_q <= FALSE;
            busy_q      <= FALSE;
            done_q      <= TRUE;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign out_last_col = out_last_col_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/matrix_fifo_reader.md
# matrix_fifo_reader

Read-side sequencer for the matrix FIFO: on `start`, it drains exactly N×N elements from a first-word-fall-through FIFO in row-major order. It presents each element to the downstream multiply datapath through a registered valid/ready output stage, tagged with row/column indices and end-of-row/end-of-matrix flags. It is the counterpart of the FIFO write-pointer/status logic: that logic fills the buffer and flags `ready`, and this block consumes the buffer.

## Interface
Parameters:
- `MAX_N`, 8: largest supported matrix dimension.
- `DATA_W`, 8: element width.
- `IDX_W`, $clog2(MAX_N): row/column index width.
- `CNT_W`, $clog2(MAX_N*MAX_N)+1: element counter width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `start`  in  1: one-cycle request to drain one matrix.
- `N`  in  4: matrix dimension (`nibble_t`), sampled only when `start` is accepted.
- `fifo_empty`  in  1: FIFO has no readable element.
- `fifo_data`  in  DATA_W: FIFO head element, valid whenever `!fifo_empty`.
- `fifo_pop`  out  1: consume the FIFO head this cycle.
- `out_data`  out  DATA_W: registered element.
- `out_valid`  out  1: `out_data` and its tags are valid.
- `out_ready`  in  1: downstream accepts on `out_valid && out_ready`.
- `out_row`, `out_col`  out  IDX_W: indices of the element in `out_data`.
- `out_last_col`  out  1: `out_col == N-1`.
- `out_last`  out  1: final element of the matrix.
- `busy`  out  1: high from `start` acceptance until `done`.
- `done`  out  1: one-cycle pulse after the last element is accepted.

## Operation
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE
  - `start` with 1 ≤ N ≤ MAX_N: latch N, clear the issue counter and the row/col counters, go to STREAM.
  - `start` with N = 0 or N > MAX_N: ignored; stay in IDLE and hold `busy` at 0.
- STREAM
  - A load occurs when `issued < N*N`, `!fifo_empty`, and the output register is free.
  - The output register is free when `!out_valid || out_ready`.
  - On a load: `fifo_pop=1`; `out_data<=fifo_data`; the current row/col go to the output tags; `issued++`.
  - Column wraps at N-1 to 0 and then increments row.
  - `out_last` is set when `issued == N*N-1` at load time.
  - When the final element is loaded, go to FLUSH.
- FLUSH: hold the output until `out_valid && out_ready && out_last`, then go to DONE.
- DONE: `done=1` for one cycle, then return to IDLE. `busy` is low from DONE onward.
- `start` outside IDLE is ignored. N changes while busy have no effect.
- `fifo_pop` is never asserted when `fifo_empty=1`, and never more than N*N times per `start`.
- Output accepted with no new load: `out_valid<=0`.
- Accept and load in the same cycle: the register is replaced and `out_valid` stays 1, giving full throughput.
- `fifo_empty` mid-matrix: stall without a bubble penalty beyond the empty cycles. Indices are preserved.
- Arithmetic:
  - N*N is computed in CNT_W bits (64 for MAX_N=8; CNT_W=7).
  - The issue counter never exceeds N*N.
  - Indices are unsigned and wrap only at N-1.

## Timing
- Reset values: state IDLE; `fifo_pop=0`, `out_valid=0`, `out_data=0`, `out_row=0`, `out_col=0`, `out_last_col=0`, `out_last=0`, `busy=0`, `done=0`. All counters are 0.
- `rst` mid-matrix: outputs return to reset values on the next edge. Elements already popped are dropped. No `done` pulse is produced.
- `start` accepted at edge k: `busy=1` after edge k, and the first `fifo_pop` can occur in cycle k+1.
- Pop-to-output latency: element popped in cycle c appears on `out_data` with `out_valid=1` after edge c.
- Throughput: 1 element/cycle with FIFO non-empty and `out_ready=1`. Minimum matrix time is N*N+2 cycles from `start` to `done`.
- `fifo_pop` is combinational from state, counters, `fifo_empty`, `out_valid` and `out_ready`. All other outputs are registered.

## Structure
- `fifo_pkg` holds:
  - `MAX_N`, `DATA_W`, `IDX_W`, `CNT_W`;
  - `nibble_t` and the element counter type;
  - the reader state enum (`reader_state_t`).
- `global_pkg` TRUE/FALSE constants are used for flags.
- Sub-module `rc_counter`: row/column index counter with `clr`, `inc` and dimension `N` inputs, and `col`, `row`, `last_col`, `last` outputs. It is instantiated once.

## Test plan
- N=3, FIFO preloaded 1..9, `out_ready=1`:
  - 9 pops on consecutive cycles;
  - outputs 1..9 with (row,col) (0,0)…(2,2);
  - `out_last_col` on 3, 6, 9 and `out_last` on 9;
  - `done` 11 cycles after `start`.
- N=2, `out_ready` toggling 1,0,1,0: each element is held stable while stalled, no duplicates or drops, exactly 4 pops.
- N=4, `fifo_empty` forced high for 5 cycles after element 6: no pop during empty, indices resume at (1,2), total 16 pops.
- `start` with N=0, then N=9: `busy` stays 0, zero pops. A second `start` during an N=2 drain is ignored.
- `rst` asserted after 5 of 9 elements (N=3): next cycle all outputs are 0, no `done`. A new `start` N=1 outputs one element with `out_last=1`.
- N=8, FIFO with 64 elements: 64 pops, final tag (7,7). The counter never reaches 65 even with the FIFO still non-empty.
